// File: rtl/vga_sync_generator_if.sv
// Signal bundle between the VGA sync generator, its pixel source and the DAC pins.
// master = generator side, slave = pixel source / pin consumer side.
interface vga_sync_generator_if #(
    parameter int unsigned COLOR_W = 4
);
    logic                   enable;
    logic [3*COLOR_W-1:0]   rgb_in;
    logic [10:0]            display_col;
    logic [9:0]             display_row;
    logic                   visible;
    logic                   line_start;
    logic                   frame_start;
    logic                   vga_hsync;
    logic                   vga_vsync;
    logic [3*COLOR_W-1:0]   vga_rgb;

    modport master (
        input  enable,
        input  rgb_in,
        output display_col,
        output display_row,
        output visible,
        output line_start,
        output frame_start,
        output vga_hsync,
        output vga_vsync,
        output vga_rgb
    );

    modport slave (
        output enable,
        output rgb_in,
        input  display_col,
        input  display_row,
        input  visible,
        input  line_start,
        input  frame_start,
        input  vga_hsync,
        input  vga_vsync,
        input  vga_rgb
    );
endinterface

// File: rtl/vga_sync_generator.sv
// 800x600@72 VGA timing: H/V counters, sync/blank decode, two-stage pin pipeline.
// Define TEST_PATTERN_EN to replace rgb_in with eight vertical colour bars.
module vga_sync_generator #(
    parameter int unsigned H_VISIBLE = 800,
    parameter int unsigned H_FRONT   = 56,
    parameter int unsigned H_SYNC    = 120,
    parameter int unsigned H_BACK    = 64,
    parameter int unsigned V_VISIBLE = 600,
    parameter int unsigned V_FRONT   = 37,
    parameter int unsigned V_SYNC    = 6,
    parameter int unsigned V_BACK    = 23,
    parameter bit          SYNC_POL  = 1'b1,
    parameter int unsigned COLOR_W   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    vga_sync_generator_if.master bus
);
    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned RGB_W    = 3 * COLOR_W;

    logic [10:0]      h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             hs, vs, vis;
    logic             hs_d1, vs_d1, vis_d1;
    logic             hsync_q, vsync_q;
    logic [RGB_W-1:0] rgb_q, pixel;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!bus.enable) begin
            h_d = '0;
            v_d = '0;
        end else if (h_q == 11'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == 10'(V_TOTAL - 1)) ? '0 : v_q + 10'd1;
        end else begin
            h_d = h_q + 11'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Stage 0 decode; gated by enable so a stopped generator shows blank, inactive syncs.
    always_comb begin
        vis = bus.enable && (h_q < 11'(H_VISIBLE)) && (v_q < 10'(V_VISIBLE));
        hs  = bus.enable && (h_q >= 11'(HS_START)) && (h_q < 11'(HS_END));
        vs  = bus.enable && (v_q >= 10'(VS_START)) && (v_q < 10'(VS_END));
    end

`ifdef TEST_PATTERN_EN
    localparam int unsigned BAR_W = H_VISIBLE / 8;

    logic [10:0] col_d1;
    logic [2:0]  bar;
    logic        unused_rgb_in;

    assign unused_rgb_in = ^bus.rgb_in;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) col_d1 <= '0;
        else       col_d1 <= h_q;
    end

    // Only sampled while visible, so the bar index is always 0..7.
    always_comb begin
        bar   = 3'(col_d1 / 11'(BAR_W));
        pixel = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}};
    end
`else
    always_comb pixel = bus.rgb_in;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hs_d1   <= 1'b0;
            vs_d1   <= 1'b0;
            vis_d1  <= 1'b0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            rgb_q   <= '0;
        end else begin
            hs_d1   <= hs;
            vs_d1   <= vs;
            vis_d1  <= vis;
            hsync_q <= hs_d1 ? SYNC_POL : ~SYNC_POL;
            vsync_q <= vs_d1 ? SYNC_POL : ~SYNC_POL;
            rgb_q   <= vis_d1 ? pixel : '0;
        end
    end

    assign bus.display_col = h_q;
    assign bus.display_row = v_q;
    assign bus.visible     = vis;
    assign bus.line_start  = bus.enable && (h_q == 11'd0);
    assign bus.frame_start = bus.enable && (h_q == 11'd0) && (v_q == 10'd0);
    assign bus.vga_hsync   = hsync_q;
    assign bus.vga_vsync   = vsync_q;
    assign bus.vga_rgb     = rgb_q;
endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: directed timing table, enable/reset sequences and randomized
// stimulus against a linear-pixel-index reference model. Vertical timing shrunk to keep runs short.
module tb_vga_sync_generator;
    localparam int unsigned HV = 800, HF = 56, HS = 120, HB = 64;
    localparam int unsigned VV = 20, VF = 3, VS = 2, VB = 3;
    localparam int unsigned HT = HV + HF + HS + HB;
    localparam int unsigned VT = VV + VF + VS + VB;
    localparam int unsigned FT = HT * VT;
    localparam bit          POL = 1'b1;
    localparam int          NT = 26;

    typedef struct {
        int unsigned n;
        int unsigned col;
        int unsigned row;
        bit          vis;
        bit          ls;
        bit          fs;
        bit          hs;
        bit          vs;
        logic [11:0] rgb;
        logic [11:0] rgb_pat;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    vga_sync_generator_if #(.COLOR_W(4)) vif ();

    vga_sync_generator #(
        .V_VISIBLE(VV),
        .V_FRONT  (VF),
        .V_SYNC   (VS),
        .V_BACK   (VB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (vif)
    );

    always #10 clock = ~clock;

    // Reference model: p is the linear pixel index row*HT+col.
    int unsigned p, p_last, s1_col;
    bit          en_cur, s1_hs, s1_vs, s1_vis, pin_hs, pin_vs;
    logic [11:0] pin_rgb;

    function automatic logic [37:0] pack(input int unsigned col, input int unsigned row,
                                         input bit vis, input bit ls, input bit fs,
                                         input bit hs, input bit vs, input logic [11:0] rgb);
        return {11'(col), 10'(row), vis, ls, fs, hs, vs, rgb};
    endfunction

    function automatic logic [37:0] obs();
        return {vif.display_col, vif.display_row, vif.visible, vif.line_start, vif.frame_start,
                vif.vga_hsync, vif.vga_vsync, vif.vga_rgb};
    endfunction

    function automatic logic [11:0] bar_rgb(input int unsigned col);
        int unsigned k;
        k = col / (HV / 8);
        return {{4{k[2]}}, {4{k[1]}}, {4{k[0]}}};
    endfunction

    function automatic logic [11:0] src_rgb(input int unsigned idx);
        int unsigned col, row;
        col = idx % HT;
        row = idx / HT;
        return {4'(col), 4'(row), 4'hA};
    endfunction

    task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        p = 0; p_last = 0; s1_col = 0;
        s1_hs = 0; s1_vs = 0; s1_vis = 0;
        pin_hs = !POL; pin_vs = !POL; pin_rgb = 12'h000;
        en_cur = vif.enable;
    endtask

    task automatic model_check();
        int unsigned col, row;
        col = p % HT;
        row = p / HT;
        check("cycle", obs(), pack(col, row, en_cur && col < HV && row < VV, en_cur && col == 0,
                                   en_cur && p == 0, pin_hs, pin_vs, pin_rgb));
    endtask

    // Drive one cycle of inputs, advance the model across the next rising edge, then compare.
    task automatic step(input bit en_new, input bit rand_rgb);
        int unsigned col, row;
        bit          hs0, vs0, vis0;
        logic [11:0] rgb_new;
        rgb_new = rand_rgb ? 12'($urandom) : src_rgb(p_last);
        vif.enable = en_new;
        vif.rgb_in = rgb_new;
        en_cur = en_new;
        col = p % HT;
        row = p / HT;
        hs0  = en_new && col >= HV + HF && col < HV + HF + HS;
        vs0  = en_new && row >= VV + VF && row < VV + VF + VS;
        vis0 = en_new && col < HV && row < VV;
        pin_hs = s1_hs ? POL : !POL;
        pin_vs = s1_vs ? POL : !POL;
`ifdef TEST_PATTERN_EN
        pin_rgb = s1_vis ? bar_rgb(s1_col) : 12'h000;
`else
        pin_rgb = s1_vis ? rgb_new : 12'h000;
`endif
        s1_hs = hs0; s1_vs = vs0; s1_vis = vis0; s1_col = col;
        p_last = p;
        p = en_new ? (p + 1) % FT : 0;
        @(negedge clock);
        model_check();
    endtask

    task automatic seek(input int unsigned target, input int unsigned budget);
        int unsigned k;
        k = 0;
        while (p != target && k < budget) begin
            step(1'b1, 1'b0);
            k++;
        end
        if (p != target) begin
            failures++;
            $display("FAIL seek: model index %0d, required %0d within %0d cycles", p, target, budget);
        end
    endtask

    vec_t        tbl[NT];
    int unsigned n;
    int unsigned hold;
    logic [11:0] exp_rgb;

    initial begin
        tbl[0]  = '{0,     0,   0,  1, 1, 1, 0, 0, 12'h000, 12'h000};
        tbl[1]  = '{1,     1,   0,  1, 0, 0, 0, 0, 12'h000, 12'h000};
        tbl[2]  = '{2,     2,   0,  1, 0, 0, 0, 0, 12'h00A, 12'h000};
        tbl[3]  = '{19,    19,  0,  1, 0, 0, 0, 0, 12'h10A, 12'h000};
        tbl[4]  = '{102,   102, 0,  1, 0, 0, 0, 0, 12'h40A, 12'h00F};
        tbl[5]  = '{702,   702, 0,  1, 0, 0, 0, 0, 12'hC0A, 12'hFFF};
        tbl[6]  = '{799,   799, 0,  1, 0, 0, 0, 0, 12'hD0A, 12'hFFF};
        tbl[7]  = '{800,   800, 0,  0, 0, 0, 0, 0, 12'hE0A, 12'hFFF};
        tbl[8]  = '{801,   801, 0,  0, 0, 0, 0, 0, 12'hF0A, 12'hFFF};
        tbl[9]  = '{802,   802, 0,  0, 0, 0, 0, 0, 12'h000, 12'h000};
        tbl[10] = '{857,   857, 0,  0, 0, 0, 0, 0, 12'h000, 12'h000};
        tbl[11] = '{858,   858, 0,  0, 0, 0, 1, 0, 12'h000, 12'h000};
        tbl[12] = '{977,   977, 0,  0, 0, 0, 1, 0, 12'h000, 12'h000};
        tbl[13] = '{978,   978, 0,  0, 0, 0, 0, 0, 12'h000, 12'h000};
        tbl[14] = '{1040,  0,   1,  1, 1, 0, 0, 0, 12'h000, 12'h000};
        tbl[15] = '{1042,  2,   1,  1, 0, 0, 0, 0, 12'h01A, 12'h000};
        tbl[16] = '{1897,  857, 1,  0, 0, 0, 0, 0, 12'h000, 12'h000};
        tbl[17] = '{1898,  858, 1,  0, 0, 0, 1, 0, 12'h000, 12'h000};
        tbl[18] = '{19762, 2,   19, 1, 0, 0, 0, 0, 12'h03A, 12'h000};
        tbl[19] = '{20802, 2,   20, 0, 0, 0, 0, 0, 12'h000, 12'h000};
        tbl[20] = '{23921, 1,   23, 0, 0, 0, 0, 0, 12'h000, 12'h000};
        tbl[21] = '{23922, 2,   23, 0, 0, 0, 0, 1, 12'h000, 12'h000};
        tbl[22] = '{26001, 1,   25, 0, 0, 0, 0, 1, 12'h000, 12'h000};
        tbl[23] = '{26002, 2,   25, 0, 0, 0, 0, 0, 12'h000, 12'h000};
        tbl[24] = '{29120, 0,   0,  1, 1, 1, 0, 0, 12'h000, 12'h000};
        tbl[25] = '{29122, 2,   0,  1, 0, 0, 0, 0, 12'h00A, 12'h000};

        // Reset with the generator stopped.
        reset = 1'b1;
        vif.enable = 1'b0;
        vif.rgb_in = 12'h000;
        @(negedge clock);
        @(negedge clock);
        model_reset();
        model_check();
        check("reset_pins", {vif.vga_hsync, vif.vga_vsync, vif.vga_rgb}, {!POL, !POL, 12'h000});

        // Release reset and start timing; n counts rising edges since start.
        reset = 1'b0;
        vif.enable = 1'b1;
        en_cur = 1'b1;
        #1;
        n = 0;
        for (int i = 0; i < NT; i++) begin
            while (n < tbl[i].n) begin
                step(1'b1, 1'b0);
                n++;
            end
`ifdef TEST_PATTERN_EN
            exp_rgb = tbl[i].rgb_pat;
`else
            exp_rgb = tbl[i].rgb;
`endif
            check($sformatf("tbl%0d_n%0d", i, tbl[i].n), obs(),
                  pack(tbl[i].col, tbl[i].row, tbl[i].vis, tbl[i].ls, tbl[i].fs,
                       tbl[i].hs, tbl[i].vs, exp_rgb));
        end

        // Drop enable while the counters show col 500, row 2.
        seek(2 * HT + 500, 5000);
        step(1'b0, 1'b0);
        check("drop_counters", {vif.display_col, vif.display_row, vif.visible, vif.line_start,
                                vif.frame_start}, 38'h0);
`ifdef TEST_PATTERN_EN
        exp_rgb = 12'hF00;
`else
        exp_rgb = 12'h32A;
`endif
        check("drop_pins_1", {vif.vga_hsync, vif.vga_vsync, vif.vga_rgb}, {!POL, !POL, exp_rgb});
        step(1'b0, 1'b0);
        check("drop_pins_2", {vif.vga_hsync, vif.vga_vsync, vif.vga_rgb}, {!POL, !POL, 12'h000});
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

        // Raise enable: frame_start is immediate at col 0, row 0.
        vif.enable = 1'b1;
        en_cur = 1'b1;
        #1;
        check("rise", {vif.display_col, vif.display_row, vif.line_start, vif.frame_start},
              {11'd0, 10'd0, 1'b1, 1'b1});

        // Asynchronous reset inside the hsync pulse.
        seek(900, 2000);
        check("pre_reset_hsync", {37'h0, vif.vga_hsync}, {37'h0, POL});
        reset = 1'b1;
        #1;
        check("async_reset", {vif.display_col, vif.display_row, vif.vga_hsync, vif.vga_vsync,
                              vif.vga_rgb}, {11'd0, 10'd0, !POL, !POL, 12'h000});
        model_reset();
        @(negedge clock);
        @(negedge clock);
        model_check();
        reset = 1'b0;

        // Randomized pixel data with occasional enable drop-outs.
        hold = 0;
        for (int i = 0; i < 15000; i++) begin
            if (hold > 0) begin
                hold--;
                step(1'b0, 1'b1);
            end else if ($urandom_range(0, 1499) == 0) begin
                hold = $urandom_range(0, 3);
                step(1'b0, 1'b1);
            end else begin
                step(1'b1, 1'b1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
